// File: rtl/arb_2x1_stream.sv
// Two-input round-robin stream arbiter with a one-entry registered output stage.
// Also keeps saturating per-channel counts of accepted beats.
module arb_2x1_stream #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i0_valid,
    input  logic [DW-1:0] i0_data,
    output logic          i0_ready,
    input  logic          i1_valid,
    input  logic [DW-1:0] i1_data,
    output logic          i1_ready,
    output logic          sel,
    output logic          y_valid,
    output logic [DW-1:0] y,
    output logic          y_src,
    input  logic          y_ready,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic [DW-1:0] y_q, y_d;
    logic          src_q, src_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic          load;
    logic          accept;

    // Grant select: the lone requester wins; on contention the other channel from last
    always_comb begin
        sel = last_q;
        unique case ({i1_valid, i0_valid})
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_q;
            default: sel = last_q;
        endcase
    end

    assign load     = (state_q == EMPTY) | y_ready;
    assign i0_ready = rst_n & load & i0_valid & ~sel;
    assign i1_ready = rst_n & load & i1_valid &  sel;
    assign accept   = i0_ready | i1_ready;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        src_d   = src_q;
        last_d  = last_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        if (accept) begin
            y_d    = sel ? i1_data : i0_data;
            src_d  = sel;
            last_d = sel;
            if (sel) begin
                cnt1_d = (cnt1_q == CNT_MAX) ? cnt1_q : cnt1_q + CW'(1);
            end else begin
                cnt0_d = (cnt0_q == CNT_MAX) ? cnt0_q : cnt0_q + CW'(1);
            end
        end

        unique case (state_q)
            EMPTY: begin
                if (accept) state_d = FULL;
            end
            FULL: begin
                if (y_ready) state_d = accept ? FULL : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; last resets to 1 so channel 0 wins the first contention
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            y_q     <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign y_valid = (state_q == FULL);
    assign y       = y_q;
    assign y_src   = src_q;
    assign cnt0    = cnt0_q;
    assign cnt1    = cnt1_q;

    // Structural invariants of the handshake
    a_one_ready : assert property (@(posedge clk) !(i0_ready && i1_ready));
    a_hold      : assert property (@(posedge clk) disable iff (!rst_n)
                      (y_valid && !y_ready) |=> (y_valid && $stable(y) && $stable(y_src)));

endmodule

// File: tb/tb_arb_2x1_stream.sv
// Bench for arb_2x1_stream: directed scenarios plus a randomized scoreboard run.
module tb_arb_2x1_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i0_valid = 1'b0, i1_valid = 1'b0, y_ready = 1'b0;
    logic [7:0] i0_data = 8'h00, i1_data = 8'h00;

    logic       i0_ready, i1_ready, sel, y_valid, y_src;
    logic [7:0] y, cnt0, cnt1;

    logic       s_i0_ready, s_i1_ready, s_sel, s_y_valid, s_y_src;
    logic [7:0] s_y;
    logic [1:0] s_cnt0, s_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    arb_2x1_stream #(.DW(8), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
        .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
        .sel(sel), .y_valid(y_valid), .y(y), .y_src(y_src), .y_ready(y_ready),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    arb_2x1_stream #(.DW(8), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(s_i0_ready),
        .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(s_i1_ready),
        .sel(s_sel), .y_valid(s_y_valid), .y(s_y), .y_src(s_y_src), .y_ready(y_ready),
        .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    // Reference model: round-robin pointer, occupancy and a scoreboard of held beats
    logic       m_last, m_full, m_sel, m_load, m_r0, m_r1;
    logic [7:0] m_cnt0, m_cnt1;
    logic [8:0] sb_q[$];

    always_comb begin
        if (i0_valid && i1_valid) m_sel = ~m_last;
        else if (i1_valid)        m_sel = 1'b1;
        else if (i0_valid)        m_sel = 1'b0;
        else                      m_sel = m_last;
        m_load = !m_full || y_ready;
        m_r0   = rst_n && m_load && i0_valid && !m_sel;
        m_r1   = rst_n && m_load && i1_valid &&  m_sel;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            m_last <= 1'b1;
            m_full <= 1'b0;
            m_cnt0 <= 8'd0;
            m_cnt1 <= 8'd0;
        end else begin
            if (m_full && y_ready) void'(sb_q.pop_front());
            if (m_r0) begin
                sb_q.push_back({1'b0, i0_data});
                m_last <= 1'b0;
                if (m_cnt0 != 8'hFF) m_cnt0 <= m_cnt0 + 8'd1;
            end else if (m_r1) begin
                sb_q.push_back({1'b1, i1_data});
                m_last <= 1'b1;
                if (m_cnt1 != 8'hFF) m_cnt1 <= m_cnt1 + 8'd1;
            end
            if (m_r0 || m_r1)  m_full <= 1'b1;
            else if (y_ready)  m_full <= 1'b0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; i0_valid = 1'b0; i1_valid = 1'b0; y_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; i0_valid = 1'b1; i1_valid = 1'b1; y_ready = 1'b1;
        #1;
        n_checks++;
        if ({i0_ready, i1_ready} !== 2'b00) begin
            n_errors++; $display("FAIL reset_readies got=%b exp=00", {i0_ready, i1_ready});
        end
        @(posedge clk); @(negedge clk); #1;
        n_checks++;
        if ({y_valid, y_src, y, cnt0, cnt1} !== 26'd0) begin
            n_errors++;
            $display("FAIL reset_state got v=%b src=%b y=%h c0=%0d c1=%0d exp all 0",
                     y_valid, y_src, y, cnt0, cnt1);
        end
        rst_n = 1'b1; i0_valid = 1'b0; i1_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        i0_valid = 1'b1; i0_data = 8'hA5; i1_valid = 1'b0; y_ready = 1'b1;
        #1;
        n_checks++;
        if ({i0_ready, i1_ready, sel} !== 3'b100) begin
            n_errors++; $display("FAIL single_grant got r0r1sel=%b exp=100", {i0_ready, i1_ready, sel});
        end
        @(posedge clk); @(negedge clk);
        i0_valid = 1'b0;
        #1;
        n_checks++;
        if ({y_valid, y_src, y, cnt0} !== {1'b1, 1'b0, 8'hA5, 8'd1}) begin
            n_errors++;
            $display("FAIL single_out got v=%b src=%b y=%h c0=%0d exp v=1 src=0 y=a5 c0=1",
                     y_valid, y_src, y, cnt0);
        end
        @(posedge clk); @(negedge clk); #1;
        n_checks++;
        if (y_valid !== 1'b0) begin
            n_errors++; $display("FAIL drain_empty got y_valid=%b exp=0", y_valid);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        i0_valid = 1'b1; i0_data = 8'h11; i1_valid = 1'b1; i1_data = 8'h22; y_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (sel !== k[0]) begin
                n_errors++; $display("FAIL alt_sel[%0d] got=%b exp=%b", k, sel, k[0]);
            end
            @(posedge clk); @(negedge clk);
            if (k == 3) begin i0_valid = 1'b0; i1_valid = 1'b0; end
            #1;
            n_checks++;
            if ({y_valid, y_src, y} !== {1'b1, k[0], (k[0] ? 8'h22 : 8'h11)}) begin
                n_errors++;
                $display("FAIL alt_out[%0d] got v=%b src=%b y=%h exp v=1 src=%b y=%h",
                         k, y_valid, y_src, y, k[0], (k[0] ? 8'h22 : 8'h11));
            end
        end
        n_checks++;
        if ({cnt0, cnt1} !== {8'd2, 8'd2}) begin
            n_errors++; $display("FAIL alt_counts got c0=%0d c1=%0d exp 2 2", cnt0, cnt1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        i0_valid = 1'b1; i0_data = 8'h11; i1_valid = 1'b1; i1_data = 8'h22; y_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({i0_ready, i1_ready, y_valid, y} !== {2'b00, 1'b1, 8'h11}) begin
                n_errors++;
                $display("FAIL bp_hold[%0d] got r0=%b r1=%b v=%b y=%h exp r=00 v=1 y=11",
                         k, i0_ready, i1_ready, y_valid, y);
            end
            @(posedge clk); @(negedge clk);
        end
        y_ready = 1'b1;
        #1;
        n_checks++;
        if ({i0_ready, i1_ready} !== 2'b01) begin
            n_errors++; $display("FAIL bp_release got r0r1=%b exp=01", {i0_ready, i1_ready});
        end
        @(posedge clk); @(negedge clk);
        i0_valid = 1'b0; i1_valid = 1'b0;
        #1;
        n_checks++;
        if ({y_valid, y_src, y} !== {1'b1, 1'b1, 8'h22}) begin
            n_errors++;
            $display("FAIL bp_next got v=%b src=%b y=%h exp v=1 src=1 y=22", y_valid, y_src, y);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        i0_valid = 1'b1; i1_valid = 1'b0; y_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i0_data = 8'(8'h30 + k);
            @(posedge clk); @(negedge clk); #1;
            n_checks++;
            if (s_cnt0 !== ((k < 2) ? 2'(k + 1) : 2'd3)) begin
                n_errors++;
                $display("FAIL sat_cnt0[%0d] got=%0d exp=%0d", k, s_cnt0, (k < 2) ? k + 1 : 3);
            end
            n_checks++;
            if ({s_y_valid, s_y_src, s_y, s_sel, s_i0_ready, s_i1_ready, s_cnt1, cnt0}
                    !== {1'b1, 1'b0, 8'(8'h30 + k), 1'b0, 1'b1, 1'b0, 2'd0, 8'(k + 1)}) begin
                n_errors++;
                $display("FAIL sat_path[%0d] got v=%b src=%b y=%h sel=%b r0=%b r1=%b c1=%0d wide_c0=%0d",
                         k, s_y_valid, s_y_src, s_y, s_sel, s_i0_ready, s_i1_ready, s_cnt1, cnt0);
            end
        end
        i0_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        i0_valid = 1'b1; i0_data = 8'h11; i1_valid = 1'b1; i1_data = 8'h22; y_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0; y_ready = 1'b1;
        #1;
        n_checks++;
        if ({i0_ready, i1_ready} !== 2'b00) begin
            n_errors++; $display("FAIL mid_rst_readies got=%b exp=00", {i0_ready, i1_ready});
        end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; y_ready = 1'b0;
        #1;
        n_checks++;
        if ({y_valid, y, cnt0, cnt1} !== 25'd0) begin
            n_errors++;
            $display("FAIL mid_rst_state got v=%b y=%h c0=%0d c1=%0d exp all 0", y_valid, y, cnt0, cnt1);
        end
        n_checks++;
        if ({i0_ready, i1_ready} !== 2'b10) begin
            n_errors++; $display("FAIL mid_rst_first got r0r1=%b exp=10", {i0_ready, i1_ready});
        end
        @(posedge clk); @(negedge clk);
        i0_valid = 1'b0; i1_valid = 1'b0;
        #1;
        n_checks++;
        if ({y_valid, y_src, y} !== {1'b1, 1'b0, 8'h11}) begin
            n_errors++;
            $display("FAIL mid_rst_beat got v=%b src=%b y=%h exp v=1 src=0 y=11", y_valid, y_src, y);
        end
    endtask

    task automatic test_random();
        int w0 = 0;
        int w1 = 0;
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            i0_valid = 1'($urandom_range(0, 1));
            i1_valid = 1'($urandom_range(0, 1));
            y_ready  = ($urandom_range(0, 3) != 0);
            i0_data  = 8'($urandom);
            i1_data  = 8'($urandom);
            #1;
            n_checks++;
            if ({i0_ready, i1_ready, sel} !== {m_r0, m_r1, m_sel}) begin
                n_errors++;
                $display("FAIL rnd_grant[%0d] got r0r1sel=%b exp=%b", c,
                         {i0_ready, i1_ready, sel}, {m_r0, m_r1, m_sel});
            end
            n_checks++;
            if (y_valid !== m_full || (m_full && {y_src, y} !== sb_q[0])) begin
                n_errors++;
                $display("FAIL rnd_out[%0d] got v=%b src_y=%h exp v=%b src_y=%h", c,
                         y_valid, {y_src, y}, m_full, m_full ? sb_q[0] : 9'h0);
            end
            n_checks++;
            if ({cnt0, cnt1} !== {m_cnt0, m_cnt1}) begin
                n_errors++;
                $display("FAIL rnd_cnt[%0d] got c0=%0d c1=%0d exp %0d %0d", c, cnt0, cnt1, m_cnt0, m_cnt1);
            end
            if (!i0_valid || i0_ready) w0 = 0; else if (i1_ready) w0++;
            if (!i1_valid || i1_ready) w1 = 0; else if (i0_ready) w1++;
            n_checks++;
            if (w0 > 2 || w1 > 2) begin
                n_errors++; $display("FAIL rnd_fair[%0d] got waits %0d %0d exp <=2", c, w0, w1);
            end
        end
        @(negedge clk);
        i0_valid = 1'b0; i1_valid = 1'b0; y_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_saturate();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
